icache_fetch_queue: RTL and testbench

Parametrised instruction-fetch front end. It holds the architectural fetch PC and a direct-mapped instruction cache of configurable size, with a single-outstanding miss path to the memory arbiter. Fetched words go into a configurable-depth instruction queue, so fetch is decoupled from issue stalls. It sits between the memory arbiter and the issue stage, and takes redirects from the ROB on misbranch.

---
 rtl/icache_fetch_queue_pkg.sv | 11 +
 rtl/icache_fetch_queue_fetch_iq.sv | 41 ++++
 rtl/icache_fetch_queue.sv | 107 ++++++++++
 tb/tb_icache_fetch_queue.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/icache_fetch_queue_pkg.sv
// icache_fetch_queue_pkg: shared widths, constants and fetch FSM state encodings
package icache_fetch_queue_pkg;
  localparam int ADDR_LEN = 32;
  localparam int DATA_LEN = 32;
  localparam int INST_LEN = 32;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic [ADDR_LEN-1:0] ZERO_ADDR = '0;
  localparam int FETCH_STATE_W = 2;
  typedef enum logic [FETCH_STATE_W-1:0] {IDLE, LOOKUP, MISS_WAIT, DRAIN} fetch_state_t;
endpackage

// File: rtl/icache_fetch_queue_fetch_iq.sv
// fetch_iq: synchronous FIFO of {pc, inst} entries decoupling fetch from issue
module fetch_iq #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr, rd;
  logic [PW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (PW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push && (!full || pop);
  assign do_pop = pop && !empty;
  assign dout = empty ? '0 : mem[rd];
  // pointers wrap naturally at DEPTH; clear wins over push and pop
  always_ff @(posedge clk) begin
    if (rst || (en && clear)) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else if (en) begin
      wr <= wr + PW'(do_push);
      rd <= rd + PW'(do_pop);
      cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
  // entry storage, no reset needed since empty masks the head
  always_ff @(posedge clk) if (en && !clear && do_push) mem[wr] <= din;
endmodule

// File: rtl/icache_fetch_queue.sv
// icache_fetch_queue: fetch PC, direct-mapped icache with one outstanding miss, and instruction queue
module icache_fetch_queue
  import icache_fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int ICACHE_SETS = 256,
  parameter int IQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        fence_i,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data,
  output logic        iq_valid,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  input  logic        issue_ready
);
  localparam int IDX_W = $clog2(ICACHE_SETS);
  localparam int TAG_W = ADDR_LEN - IDX_W - 2;
  fetch_state_t state, state_n;
  logic [ADDR_LEN-1:0] pc, pc_n;
  logic [ICACHE_SETS-1:0] valid;
  logic [TAG_W-1:0] tags [ICACHE_SETS];
  logic [DATA_LEN-1:0] words [ICACHE_SETS];
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [INST_LEN-1:0] enq_inst;
  logic hit, full, empty, push, req, fill;
  assign idx = pc[IDX_W+1:2];
  assign tag = pc[ADDR_LEN-1:IDX_W+2];
  assign hit = valid[idx] && tags[idx] == tag;
  assign enq_inst = state == MISS_WAIT ? mem_data : words[idx];
  assign iq_valid = !empty;
  fetch_iq #(.DEPTH(IQ_DEPTH), .W(ADDR_LEN + INST_LEN)) iq (
    .clk(clk),
    .rst(rst),
    .en(rdy),
    .clear(flush),
    .push(push),
    .pop(issue_ready),
    .din({pc, enq_inst}),
    .dout({iq_pc, iq_inst}),
    .full(full),
    .empty(empty)
  );
  // FSM state register
  always_ff @(posedge clk) state <= rst ? IDLE : rdy ? state_n : state;
  // next state and fetch control; a flush with a response still owed waits in DRAIN
  always_comb begin
    state_n = state;
    pc_n = pc;
    push = 1'b0;
    req = 1'b0;
    fill = 1'b0;
    if (flush) begin
      pc_n = flush_pc;
      state_n = ((state == MISS_WAIT || state == DRAIN) && !mem_valid) ? DRAIN : LOOKUP;
    end else begin
      case (state)
        IDLE: state_n = LOOKUP;
        LOOKUP: if (!full && !(hit && fence_i)) begin
          if (hit) begin
            push = enq_inst != '0;
            pc_n = pc + 32'd4;
          end else begin
            req = 1'b1;
            state_n = MISS_WAIT;
          end
        end
        MISS_WAIT: if (mem_valid) begin
          fill = 1'b1;
          push = enq_inst != '0;
          pc_n = pc + 32'd4;
          state_n = LOOKUP;
        end
        DRAIN: if (mem_valid) state_n = LOOKUP;
        default: state_n = IDLE;
      endcase
    end
  end
  // pc, miss request and valid bits; a refill lands after a same-cycle fence clear
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      mem_req <= FALSE;
      mem_addr <= ZERO_ADDR;
      valid <= '0;
    end else if (rdy) begin
      pc <= pc_n;
      mem_req <= req;
      if (req) mem_addr <= pc;
      if (fence_i) valid <= '0;
      if (fill) valid[idx] <= TRUE;
    end
  end
  // line tag and data written on refill
  always_ff @(posedge clk) if (rdy && fill) begin
    tags[idx] <= tag;
    words[idx] <= mem_data;
  end
endmodule

// File: tb/tb_icache_fetch_queue.sv
// tb_icache_fetch_queue: random fetch/flush/stall traffic checked against the architectural instruction stream
module tb_icache_fetch_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1, flush = 1'b0, fence_i = 1'b0, issue_ready = 1'b0, mem_valid = 1'b0;
  logic mem_req, iq_valid;
  logic [31:0] flush_pc = '0, mem_data = '0;
  logic [31:0] mem_addr, iq_inst, iq_pc;
  logic [31:0] arr [1024];
  logic [63:0] exp_q [$];
  logic [31:0] req_log [$];
  logic [63:0] e_mon;
  logic [31:0] paddr = '0;
  logic pend = 1'b0, prev_rdy = 1'b0;
  int checks = 0, errors = 0, pops = 0, force_dly = -1, dly = 0, since = 0;

  icache_fetch_queue #(.RESET_PC(32'h0), .ICACHE_SETS(256), .IQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .flush_pc(flush_pc), .fence_i(fence_i),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
    .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc), .issue_ready(issue_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mword(input logic [31:0] a);
    return a < 32'h1000 ? arr[a[11:2]] : 32'h13;
  endfunction

  // expected issue stream from a start pc: every nonzero word in address order
  task automatic restart(input logic [31:0] start);
    logic [31:0] a;
    a = start;
    exp_q.delete();
    repeat (64) begin
      while (mword(a) == 32'h0) a += 32'd4;
      exp_q.push_back({a, mword(a)});
      a += 32'd4;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] req_at(input int i);
    return i < req_log.size() ? req_log[i] : 32'hdead_beef;
  endfunction

  // stall until the queue is full and no miss is pending, then redirect and watch the fetch path
  task automatic flush_expect(input logic [31:0] t, input bit miss);
    int n;
    issue_ready = 1'b0;
    repeat (50) step();
    n = req_log.size();
    flush = 1'b1;
    flush_pc = t;
    restart(t);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_clears_queue", 32'(iq_valid), 32'd1 ^ 32'd1);
    if (!miss) begin
      step();
      @(negedge clk);
      chk("hit_latency_valid", 32'(iq_valid), 32'd1);
      chk("hit_latency_pc", iq_pc, t);
    end
    repeat (30) step();
    if (miss) chk("miss_req_addr", req_at(n), t);
    else chk("hit_no_req", 32'(req_log.size()), 32'(n));
    issue_ready = 1'b1;
    repeat (8) step();
  endtask

  // memory arbiter: one response per request, only while rdy is high
  initial forever begin
    @(posedge clk);
    #2;
    if (rst) begin
      pend = 1'b0;
      mem_valid = 1'b0;
      prev_rdy = 1'b0;
    end else begin
      if (prev_rdy && mem_req) begin
        checks++;
        if (pend) begin
          errors++;
          $display("FAIL second_req: got request %h while %h outstanding", mem_addr, paddr);
        end
        pend = 1'b1;
        paddr = mem_addr;
        req_log.push_back(mem_addr);
        dly = force_dly >= 0 ? force_dly : int'($urandom_range(0, 3));
      end
      mem_valid = 1'b0;
      if (pend && rdy) begin
        if (dly == 0) begin
          mem_valid = 1'b1;
          mem_data = mword(paddr);
          pend = 1'b0;
        end else dly--;
      end
      prev_rdy = rdy;
    end
  end

  // monitor: every pop must be the next word of the architectural stream
  always @(negedge clk) if (!rst && rdy && !flush && iq_valid && issue_ready) begin
    checks++;
    pops++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL pop_extra: got pc %h inst %h with nothing expected", iq_pc, iq_inst);
    end else begin
      e_mon = exp_q.pop_front();
      if ({iq_pc, iq_inst} !== e_mon) begin
        errors++;
        $display("FAIL pop_order: got pc %h inst %h expected pc %h inst %h", iq_pc, iq_inst, e_mon[63:32], e_mon[31:0]);
      end
    end
  end

  initial begin
    int n, n2;
    for (int i = 0; i < 1024; i++) arr[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
    arr[0] = 32'h0050_0093;
    arr[1] = 32'h00A0_0113;
    arr[2] = 32'h0;
    arr[3] = 32'h0030_0193;
    arr[4] = 32'h0040_0213;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_iq_valid", 32'(iq_valid), 32'd0);
    chk("reset_iq_inst", iq_inst, 32'd0);
    chk("reset_iq_pc", iq_pc, 32'd0);
    step();
    rst = 1'b0;
    restart(32'h0);
    repeat (60) step();
    chk("cold_req_count", 32'(req_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("cold_req_addr", req_at(i), 32'(i * 4));
    @(negedge clk);
    chk("cold_head_valid", 32'(iq_valid), 32'd1);
    chk("cold_head_pc", iq_pc, 32'h0);
    chk("cold_head_inst", iq_inst, 32'h0050_0093);
    issue_ready = 1'b1;
    repeat (8) step();
    flush_expect(32'h0, 1'b0);
    issue_ready = 1'b0;
    repeat (50) step();
    fence_i = 1'b1;
    step();
    fence_i = 1'b0;
    flush_expect(32'h4, 1'b1);
    issue_ready = 1'b0;
    repeat (50) step();
    n = req_log.size();
    force_dly = 4;
    flush = 1'b1;
    flush_pc = 32'h200;
    restart(32'h200);
    step();
    flush = 1'b0;
    for (int k = 0; k < 20 && req_log.size() == n; k++) step();
    chk("drain_miss_seen", 32'(req_log.size() > n), 32'd1);
    n2 = req_log.size();
    flush = 1'b1;
    flush_pc = 32'h100;
    restart(32'h100);
    step();
    flush = 1'b0;
    force_dly = -1;
    repeat (30) step();
    chk("drain_next_req", req_at(n2), 32'h100);
    flush_expect(32'h200, 1'b1);
    flush_expect(32'h0, 1'b1);
    flush_expect(32'h400, 1'b1);
    flush_expect(32'h0, 1'b1);
    since = 0;
    repeat (2000) begin
      since++;
      rdy = $urandom_range(0, 7) != 0;
      issue_ready = $urandom_range(0, 1) == 1;
      fence_i = $urandom_range(0, 29) == 0;
      if ($urandom_range(0, 29) == 0 || since >= 50) begin
        flush = 1'b1;
        rdy = 1'b1;
        flush_pc = 32'($urandom_range(0, 511)) << 2;
        restart(flush_pc);
        since = 0;
      end else flush = 1'b0;
      step();
    end
    flush = 1'b0;
    fence_i = 1'b0;
    rdy = 1'b1;
    issue_ready = 1'b1;
    repeat (20) step();
    chk("liveness_pops", 32'(pops >= 50), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
